// File: rtl/sm4_pkg.sv
// sm4_pkg
// Shared SM4 definitions used by the round engine and the round transform.
// Contents:
//   SM4_ROUNDS, SM4_BLK_W, SM4_WORD_W : cipher geometry
//   sm4_state_e                       : round-engine FSM states
//   MODE_ENC / MODE_DEC               : direction select values
//   SM4_SBOX / sm4_sbox()             : the fixed 8-bit SM4 substitution box
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;
  localparam int SM4_BLK_W  = 128;
  localparam int SM4_WORD_W = 32;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sm4_state_e;

  // Entry 0 sits in the most significant byte, so row r of the usual
  // 16x16 table printout is bits [2047-128*r -: 128].
  localparam logic [2047:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] b);
    return SM4_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/transform_for_encdec.sv
// transform_for_encdec
// The SM4 round transform T = L(tau(x)), shared by encryption and
// decryption (direction only changes the round-key order, not T).
// Ports:
//   din  [31:0] : X1 ^ X2 ^ X3 ^ rk for the current round
//   dout [31:0] : T(din), purely combinational
module transform_for_encdec
  import sm4_pkg::*;
(
  input  logic [SM4_WORD_W-1:0] din,
  output logic [SM4_WORD_W-1:0] dout
);

  logic [SM4_WORD_W-1:0] tau;

  // tau: four independent byte substitutions through the S-box.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign tau[8*i +: 8] = sm4_sbox(din[8*i +: 8]);
  end

  // L: tau xor its left rotations by 2, 10, 18 and 24 bits.
  assign dout = tau
              ^ {tau[29:0], tau[31:30]}
              ^ {tau[21:0], tau[31:22]}
              ^ {tau[13:0], tau[31:14]}
              ^ {tau[7:0],  tau[31:8]};

endmodule

// File: rtl/sm4_round_engine.sv
// sm4_round_engine
// Iterative SM4 block cipher core: one round per clock, 32 rounds per
// block, one shared round transform. Round keys come from an external key
// store addressed by rk_idx, returned combinationally on rk_in.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   flush               : synchronous abort back to IDLE
//   in_valid/in_ready   : input block handshake
//   in_mode, in_data    : 0 encrypt / 1 decrypt, block X0..X3 (MSW first)
//   rk_idx, rk_in       : round-key request index and returned key
//   busy                : high in RUN and DONE (key store must stay stable)
//   out_valid/out_ready : result handshake
//   out_data            : result block {X35, X34, X33, X32}
module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [SM4_BLK_W-1:0]  in_data,
  output logic [CNT_W-1:0]      rk_idx,
  input  logic [SM4_WORD_W-1:0] rk_in,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SM4_BLK_W-1:0]  out_data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  sm4_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;
  logic [SM4_WORD_W-1:0] x0_q, x1_q, x2_q, x3_q;
  logic [SM4_BLK_W-1:0]  out_data_q;
  logic [SM4_WORD_W-1:0] t_in, t_out, x_new;
  logic                  accept;
  logic                  last_round;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_round = (state_q == RUN) && (cnt_q == LAST_CNT);

  assign t_in  = x1_q ^ x2_q ^ x3_q ^ rk_in;
  assign x_new = x0_q ^ t_out;

  transform_for_encdec u_transform (
    .din  (t_in),
    .dout (t_out)
  );

  // FSM state register; reset lands in IDLE so every status output is at
  // its idle value without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs. flush is applied last so it overrides
  // every transition, including an input handshake in the same cycle.
  // Decrypt walks the same key store backwards.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        rk_idx = (mode_q == MODE_DEC) ? (LAST_CNT - cnt_q) : cnt_q;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Round datapath: load on handshake, shift in one new word per round,
  // capture the word-reversed result on the final round. The counter
  // returns to zero after the last round instead of running past it.
  // A flush only clears the counter; the data words keep their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mode_q     <= MODE_ENC;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      out_data_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      mode_q <= in_mode;
      x0_q   <= in_data[127:96];
      x1_q   <= in_data[95:64];
      x2_q   <= in_data[63:32];
      x3_q   <= in_data[31:0];
    end else if (state_q == RUN) begin
      x0_q <= x1_q;
      x1_q <= x2_q;
      x2_q <= x3_q;
      x3_q <= x_new;
      if (last_round) begin
        cnt_q      <= '0;
        out_data_q <= {x_new, x3_q, x2_q, x1_q};
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_sm4_round_engine.sv
// tb_sm4_round_engine
// Self-checking bench for sm4_round_engine. Holds its own key store (filled
// by a behavioural key schedule) and a word-array model of the cipher.
module tb_sm4_round_engine;

  localparam int ROUNDS = 32;
  localparam int CNT_W  = 5;

  localparam logic [127:0] KEY1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT1  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT1  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [2047:0] REF_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_mode = 1'b0;
  logic [127:0]     in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready, busy, out_valid;
  logic [CNT_W-1:0] rk_idx;
  logic [31:0]      rk_in;
  logic [127:0]     out_data;
  logic [31:0]      rk_mem [32];
  int               total = 0;
  int               bad = 0;

  always #5 clk = ~clk;

  // Key store model: combinational same-cycle return.
  assign rk_in = rk_mem[rk_idx];

  sm4_round_engine #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ref_tau(input logic [31:0] w);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      r[8*j +: 8] = REF_SBOX[2047 - 8 * int'(w[8*j +: 8]) -: 8];
    end
    return r;
  endfunction

  task automatic ref_key_expand(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] ck, b;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) begin
        ck[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      end
      b = ref_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
      rk_mem[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] ref_cipher(input logic mode, input logic [127:0] data);
    logic [31:0] x [36];
    logic [31:0] b, rk;
    x[0] = data[127:96];
    x[1] = data[95:64];
    x[2] = data[63:32];
    x[3] = data[31:0];
    for (int i = 0; i < 32; i++) begin
      rk = mode ? rk_mem[31 - i] : rk_mem[i];
      b = ref_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Handshakes one block, then runs until out_valid (bounded). edges counts
  // clock edges after the handshake edge; out_valid appearing after edge 32
  // is the 33rd cycle after the handshake cycle. in_valid/in_mode/out_ready
  // are randomised during the run because the engine must ignore them.
  task automatic run_block(input logic mode, input logic [127:0] data,
                           output logic [127:0] res, output int edges, output int seq_bad);
    int exp_idx;
    in_valid = 1'b1; in_mode = mode; in_data = data; out_ready = 1'b0;
    @(posedge clk); #1;
    edges = 0; seq_bad = 0;
    while (out_valid !== 1'b1 && edges < 100) begin
      exp_idx = mode ? (ROUNDS - 1 - edges) : edges;
      if (rk_idx !== exp_idx[CNT_W-1:0]) seq_bad++;
      in_valid = 1'($urandom); in_mode = 1'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom);
      @(posedge clk); #1; edges++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    res = out_data;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    #1;
    total++; if ({in_ready, busy, out_valid} !== 3'b100) begin bad++;
      $display("[TB] FAIL reset_flags: got %b expected 100", {in_ready, busy, out_valid}); end
    total++; if (out_data !== 128'h0 || rk_idx !== '0) begin bad++;
      $display("[TB] FAIL reset_data: got out_data=%h rk_idx=%0d expected 0/0", out_data, rk_idx); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_hold: busy got %b expected 0", busy); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_kat_encrypt();
    logic [127:0] res; int edges, seq_bad;
    ref_key_expand(KEY1);
    run_block(1'b0, PT1, res, edges, seq_bad);
    total++; if (res !== CT1) begin bad++;
      $display("[TB] FAIL kat_enc_data: got %h expected %h", res, CT1); end
    total++; if (edges !== ROUNDS) begin bad++;
      $display("[TB] FAIL kat_enc_latency: got %0d edges expected %0d", edges, ROUNDS); end
    total++; if (seq_bad !== 0) begin bad++;
      $display("[TB] FAIL kat_enc_rk_seq: got %0d wrong indices expected 0", seq_bad); end
    total++; if ({in_ready, busy} !== 2'b01) begin bad++;
      $display("[TB] FAIL kat_enc_done_flags: got %b expected 01", {in_ready, busy}); end
    drain();
    total++; if ({in_ready, busy, out_valid} !== 3'b100) begin bad++;
      $display("[TB] FAIL kat_enc_drain: got %b expected 100", {in_ready, busy, out_valid}); end
  endtask

  task automatic test_kat_decrypt();
    logic [127:0] res; int edges, seq_bad;
    ref_key_expand(KEY1);
    run_block(1'b1, CT1, res, edges, seq_bad);
    total++; if (res !== PT1) begin bad++;
      $display("[TB] FAIL kat_dec_data: got %h expected %h", res, PT1); end
    total++; if (seq_bad !== 0) begin bad++;
      $display("[TB] FAIL kat_dec_rk_seq: got %0d wrong indices expected 0", seq_bad); end
    drain();
  endtask

  task automatic test_random();
    logic [127:0] key, data, res, exp; logic mode; int edges, seq_bad;
    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'($urandom);
      ref_key_expand(key);
      exp = ref_cipher(mode, data);
      run_block(mode, data, res, edges, seq_bad);
      total++; if (res !== exp) begin bad++;
        $display("[TB] FAIL random_%0d mode=%0d: got %h expected %h", n, mode, res, exp); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] chain, exp;
    int blocks, cyc, last_hs;
    ref_key_expand(KEY1);
    chain = PT1; blocks = 0; cyc = 0; last_hs = -1;
    in_mode = 1'b0; in_data = chain; in_valid = 1'b1; out_ready = 1'b1;
    while (blocks < 20 && cyc < 2000) begin
      if (in_ready === 1'b1 && in_valid === 1'b1) begin
        if (last_hs >= 0) begin
          total++; if (cyc + 1 - last_hs !== ROUNDS + 2) begin bad++;
            $display("[TB] FAIL b2b_interval: got %0d cycles expected %0d", cyc + 1 - last_hs, ROUNDS + 2); end
        end
        last_hs = cyc + 1;
      end
      if (out_valid === 1'b1) begin
        exp = ref_cipher(1'b0, chain);
        total++; if (out_data !== exp) begin bad++;
          $display("[TB] FAIL b2b_block_%0d: got %h expected %h", blocks, out_data, exp); end
        chain = exp; in_data = exp; blocks++;
        if (blocks == 20) in_valid = 1'b0;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (blocks !== 20) begin bad++;
      $display("[TB] FAIL b2b_count: got %0d blocks expected 20", blocks); end
  endtask

  task automatic test_backpressure();
    logic [127:0] key, d0, d1, res, exp0, exp1; int edges, seq_bad, unstable, ready_bad, waited;
    key = {$urandom, $urandom, $urandom, $urandom};
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    ref_key_expand(key);
    exp0 = ref_cipher(1'b0, d0);
    exp1 = ref_cipher(1'b1, d1);
    run_block(1'b0, d0, res, edges, seq_bad);
    unstable = 0; ready_bad = 0;
    in_valid = 1'b1; in_mode = 1'b1; in_data = d1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_data !== exp0 || out_valid !== 1'b1) unstable++;
      if (in_ready !== 1'b0) ready_bad++;
    end
    total++; if (unstable !== 0) begin bad++;
      $display("[TB] FAIL bp_hold_data: got %0d unstable cycles expected 0", unstable); end
    total++; if (ready_bad !== 0) begin bad++;
      $display("[TB] FAIL bp_in_ready: got %0d cycles ready expected 0", ready_bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++;
      $display("[TB] FAIL bp_release_idle: got %b expected 10", {in_ready, out_valid}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if ({in_ready, busy} !== 2'b01) begin bad++;
      $display("[TB] FAIL bp_next_accept: got %b expected 01", {in_ready, busy}); end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 100) begin @(posedge clk); #1; waited++; end
    total++; if (out_data !== exp1 || out_valid !== 1'b1) begin bad++;
      $display("[TB] FAIL bp_second_block: got %h valid=%b expected %h", out_data, out_valid, exp1); end
    drain();
  endtask

  task automatic test_flush();
    logic [127:0] res; int edges, seq_bad, seen;
    ref_key_expand(KEY1);
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    total++; if (rk_idx !== 5'd17) begin bad++;
      $display("[TB] FAIL flush_round: rk_idx got %0d expected 17", rk_idx); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if ({in_ready, busy, out_valid} !== 3'b100) begin bad++;
      $display("[TB] FAIL flush_idle: got %b expected 100", {in_ready, busy, out_valid}); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
    total++; if (seen !== 0) begin bad++;
      $display("[TB] FAIL flush_no_output: out_valid seen %0d cycles expected 0", seen); end
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    total++; if ({in_ready, busy} !== 2'b10) begin bad++;
      $display("[TB] FAIL flush_drop_hs: got %b expected 10", {in_ready, busy}); end
    run_block(1'b0, PT1, res, edges, seq_bad);
    total++; if (res !== CT1) begin bad++;
      $display("[TB] FAIL flush_recover: got %h expected %h", res, CT1); end
    drain();
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] res; int edges, seq_bad;
    ref_key_expand(KEY1);
    in_valid = 1'b1; in_mode = 1'b0; in_data = PT1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({in_ready, busy, out_valid} !== 3'b100 || rk_idx !== '0) begin bad++;
      $display("[TB] FAIL rst_mid_flags: got %b rk_idx=%0d expected 100/0", {in_ready, busy, out_valid}, rk_idx); end
    total++; if (out_data !== 128'h0) begin bad++;
      $display("[TB] FAIL rst_mid_data: got %h expected 0", out_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(1'b1, CT1, res, edges, seq_bad);
    total++; if (res !== PT1) begin bad++;
      $display("[TB] FAIL rst_mid_decrypt: got %h expected %h", res, PT1); end
    drain();
  endtask

  // Watchdog: the bench must always terminate on its own.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_kat_encrypt();
    test_kat_decrypt();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
